fifo_rd_burst_ctrl: RTL and testbench
=====================================

// Module: fifo_rd_burst_ctrl
// PURPOSE
//   Read-side consumer of the async FIFO in the SDRAM controller write path, on the FIFO read clock.
//   Pops BURST_LEN words into a local buffer and requests an SDRAM write burst at the current address.
//   Once acknowledged, streams the buffered words to the controller with a valid/ready handshake,
//   then advances the address. Only whole bursts are issued; there are no partial bursts.
// PARAMETERS
//   WIDTH     8   data word width; must match the FIFO WIDTH
//   BURST_LEN 4   words per burst, >=2
//   ADDR_W    12  SDRAM word-address width
//   CNT_W     3   word-counter width; must satisfy 2**CNT_W > BURST_LEN
// PORTS
//   clk           in   1       single clock (FIFO read clock)
//   rst           in   1       synchronous, active-high reset
//   enable        in   1       permits starting a new burst
//   addr_load     in   1       load addr_init into the address register; honoured in IDLE only
//   addr_init     in   ADDR_W  start address
//   fifo_empty    in   1       FIFO empty flag
//   fifo_rd_en    out  1       FIFO pop request
//   fifo_rd_data  in   WIDTH   FIFO data; valid the cycle after an accepted pop
//   cmd_req       out  1       write-burst request
//   cmd_addr      out  ADDR_W  burst start address, stable while cmd_req=1
//   cmd_ack       in   1       1-cycle acceptance of cmd_req
//   wdata         out  WIDTH   burst data word
//   wdata_valid   out  1       wdata is valid
//   wdata_ready   in   1       controller accepts wdata this cycle
//   busy          out  1       state != IDLE
//   burst_done    out  1       1-cycle pulse when the last word is accepted
// BEHAVIOUR
//   Clock, reset and interface
//   - One clock; reset is synchronous and active-high.
//   - rst=1 at a clock edge: state=IDLE, all counters=0, address=0.
//     All outputs 0, except cmd_addr, which shows the address register (0).
//     Reset mid-burst discards buffered words. Words already popped from the FIFO are lost.
//   States
//   - IDLE
//     - enable=1 -> FILL.
//     - Otherwise, addr_load=1 loads addr_init.
//     - addr_load and enable together: load first; the burst uses addr_init.
//   - FILL
//     - fifo_rd_en = !fifo_empty && (issued < BURST_LEN); combinational, never asserted when empty.
//     - An accepted pop sets a pending bit. Next cycle, fifo_rd_data is written to buf[rcv], rcv++.
//     - Back-to-back pops are allowed: 1 word per cycle at full rate.
//     - rcv == BURST_LEN -> REQ. Minimum is BURST_LEN+1 cycles in FILL.
//     - enable falling during FILL does not abort; the burst completes.
//   - REQ
//     - cmd_req=1 and cmd_addr=address until cmd_ack=1, then SEND on the next cycle.
//     - There is no timeout; REQ waits indefinitely.
//   - SEND
//     - wdata_valid=1, wdata=buf[snd].
//     - wdata_ready=1 -> snd++.
//     - wdata_valid and wdata stay stable while wdata_ready=0.
//     - Acceptance of word BURST_LEN-1 -> burst_done=1 for that cycle only.
//     - On that acceptance: address <= address + BURST_LEN, modulo 2**ADDR_W (wraps silently).
//     - Counters clear. Next state is FILL if enable=1, else IDLE.
//   Other rules
//   - cmd_ack outside REQ and wdata_ready outside SEND are ignored.
//   - addr_load outside IDLE is ignored.
//   - fifo_rd_en is never asserted outside FILL.
//   - The buffer is BURST_LEN x WIDTH registers. Word order is FIFO order: buf[0] is sent first.
// TESTING
//   1. Reset:
//      - Stimulus: rst=1 for 2 cycles.
//      - Required: all outputs 0, busy=0, cmd_addr=0.
//   2. Basic burst:
//      - Stimulus: addr_init=0x010 loaded; FIFO holds 0xA1..0xA4; enable=1; cmd_ack 2 cycles after cmd_req; wdata_ready=1.
//      - Required: wdata = A1,A2,A3,A4 on consecutive cycles; burst_done once; next cmd_addr=0x014.
//   3. FIFO starvation:
//      - Stimulus: empty=1 after 2 words, for 5 cycles.
//      - Required: fifo_rd_en=0 while empty; no cmd_req until the 4th word is captured.
//   4. Backpressure:
//      - Stimulus: wdata_ready toggles 1,0,0,1,...
//      - Required: no word repeated or skipped; wdata stable while ready=0.
//   5. Address wrap:
//      - Stimulus: addr_init=0xFFC.
//      - Required: first burst at 0xFFC; second cmd_addr=0x000.
//   6. Mid-burst reset:
//      - Stimulus: rst=1 in SEND after 2 accepted words.
//      - Required: next cycle IDLE, wdata_valid=0, cmd_addr=0, no burst_done.

Source files
------------

// File: rtl/fifo_rd_burst_ctrl_if.sv
// Handshake bundle between the FIFO read-side burst controller, its FIFO and the SDRAM controller.
// The master modport is the burst controller's view; slave is the surrounding environment.
interface fifo_rd_burst_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 12
);
    logic              enable;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_init;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [WIDTH-1:0]  fifo_rd_data;
    logic              cmd_req;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ack;
    logic [WIDTH-1:0]  wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic              busy;
    logic              burst_done;

    modport master (
        input  enable, addr_load, addr_init, fifo_empty, fifo_rd_data, cmd_ack, wdata_ready,
        output fifo_rd_en, cmd_req, cmd_addr, wdata, wdata_valid, busy, burst_done
    );

    modport slave (
        output enable, addr_load, addr_init, fifo_empty, fifo_rd_data, cmd_ack, wdata_ready,
        input  fifo_rd_en, cmd_req, cmd_addr, wdata, wdata_valid, busy, burst_done
    );
endinterface

// File: rtl/fifo_rd_burst_ctrl.sv
// Drains BURST_LEN words from the async FIFO read side into a local buffer, requests an SDRAM
// write burst at the current address, streams the words out with valid/ready, then advances.
module fifo_rd_burst_ctrl #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 12,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_burst_ctrl_if.master bus
);
    localparam int              IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REQ,
        SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  rcv;
    logic [CNT_W-1:0]  snd;
    logic [ADDR_W-1:0] addr;
    logic              vld_p1;
    logic [WIDTH-1:0]  burst_buf [BURST_LEN];

    logic pop;
    logic req;
    logic wvalid;
    logic accept;
    logic done;

    function automatic logic [ADDR_W-1:0] addr_advance(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(BURST_LEN);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leave FILL on the same edge that captures the last word.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        req       = 1'b0;
        wvalid    = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                pop = !bus.fifo_empty && (issued < LEN_C);
                if (vld_p1 && (rcv == LAST_C)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.cmd_ack) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                wvalid = 1'b1;
                accept = bus.wdata_ready;
                if (accept && (snd == LAST_C)) begin
                    done      = 1'b1;
                    state_nxt = bus.enable ? FILL : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: a pop accepted now delivers its word on fifo_rd_data next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued <= '0;
            rcv    <= '0;
            snd    <= '0;
            vld_p1 <= 1'b0;
            addr   <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                issued <= issued + CNT_W'(1);
            end
            if (vld_p1) begin
                rcv <= rcv + CNT_W'(1);
            end
            if (accept) begin
                snd <= snd + CNT_W'(1);
            end
            if (done) begin
                issued <= '0;
                rcv    <= '0;
                snd    <= '0;
                addr   <= addr_advance(addr);
            end
            if ((state == IDLE) && bus.addr_load) begin
                addr <= bus.addr_init;
            end
        end
    end

    // Stage p1: capture the FIFO word into the burst buffer in arrival order.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            burst_buf[rcv[IDX_W-1:0]] <= bus.fifo_rd_data;
        end
    end

    assign bus.fifo_rd_en  = pop;
    assign bus.cmd_req     = req;
    assign bus.cmd_addr    = addr;
    assign bus.wdata_valid = wvalid;
    assign bus.wdata       = wvalid ? burst_buf[snd[IDX_W-1:0]] : '0;
    assign bus.busy        = (state != IDLE);
    assign bus.burst_done  = done;
endmodule

// File: tb/tb_fifo_rd_burst_ctrl.sv
// Randomised bench: FIFO/controller responders drive the DUT, a queue scoreboard holds the
// expected word stream and burst addresses, and a negedge monitor checks every DUT output event.
module tb_fifo_rd_burst_ctrl;
    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int ADDR_W    = 12;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_burst_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fifo_rd_burst_ctrl #(
        .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0]  fifo_q   [$];
    logic [WIDTH-1:0]  exp_data [$];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [ADDR_W-1:0] model_addr = '0;

    int n_req  = 0;
    int n_done = 0;
    int n_acc  = 0;
    int ready_mode = 0;
    int ack_delay  = 1;
    bit gaps       = 1'b0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
        end
    endtask

    // FIFO read port, command acknowledger and write-data sink.
    initial begin
        int req_cnt;
        int pat;
        bit popped;
        req_cnt = 0;
        pat     = 0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.cmd_ack      = 1'b0;
        bus.wdata_ready  = 1'b0;
        forever begin
            @(negedge clk);
            popped = bus.fifo_rd_en && !bus.fifo_empty;
            if (bus.cmd_req && !bus.cmd_ack) req_cnt++;
            else req_cnt = 0;
            @(posedge clk);
            #1;
            if (popped && fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
            bus.fifo_empty = (fifo_q.size() == 0) || (gaps && ($urandom_range(0, 2) == 0));
            bus.cmd_ack    = (req_cnt > 0) && (req_cnt >= ack_delay);
            case (ready_mode)
                0:       bus.wdata_ready = 1'b1;
                1:       bus.wdata_ready = ((pat % 3) == 0);
                default: bus.wdata_ready = 1'($urandom_range(0, 1));
            endcase
            pat++;
        end
    end

    // Monitor: compares every request, accepted word and done pulse with the scoreboard.
    logic              prev_req  = 1'b0;
    logic              prev_hold = 1'b0;
    logic [ADDR_W-1:0] prev_caddr = '0;
    logic [WIDTH-1:0]  prev_wd    = '0;
    int pops = 0, last_pop = -100, words = 0, first_acc = 0, cyc = 0;

    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [WIDTH-1:0]  ed;
        cyc++;
        if (rst) begin
            prev_req  = 1'b0;
            prev_hold = 1'b0;
            pops      = 0;
            words     = 0;
            last_pop  = -100;
        end else begin
            chk(!(bus.fifo_rd_en && bus.fifo_empty), "rd_en_while_empty", bus.fifo_rd_en, 0);
            if (bus.fifo_rd_en && !bus.fifo_empty) begin
                pops++;
                last_pop = cyc;
            end
            if (bus.cmd_req && !prev_req) begin
                n_req++;
                chk(pops == BURST_LEN, "req_word_count", pops, BURST_LEN);
                chk((cyc - last_pop) >= 2, "req_before_capture", cyc - last_pop, 2);
                chk(exp_addr.size() > 0, "unexpected_req", bus.cmd_addr, 0);
                if (exp_addr.size() > 0) begin
                    ea = exp_addr.pop_front();
                    chk(bus.cmd_addr == ea, "cmd_addr", bus.cmd_addr, ea);
                end
            end else if (bus.cmd_req) begin
                chk(bus.cmd_addr == prev_caddr, "cmd_addr_stable", bus.cmd_addr, prev_caddr);
            end
            if (prev_hold) begin
                chk(bus.wdata_valid, "valid_dropped", bus.wdata_valid, 1);
                chk(bus.wdata == prev_wd, "wdata_stable", bus.wdata, prev_wd);
            end
            if (bus.wdata_valid && bus.wdata_ready) begin
                n_acc++;
                words++;
                if (words == 1) first_acc = cyc;
                chk(exp_data.size() > 0, "unexpected_word", bus.wdata, 0);
                if (exp_data.size() > 0) begin
                    ed = exp_data.pop_front();
                    chk(bus.wdata == ed, "wdata", bus.wdata, ed);
                end
                chk(bus.burst_done == (words == BURST_LEN), "burst_done", bus.burst_done,
                    (words == BURST_LEN));
                if (words == BURST_LEN) begin
                    n_done++;
                    if (ready_mode == 0)
                        chk((cyc - first_acc) == BURST_LEN - 1, "burst_gapless",
                            cyc - first_acc, BURST_LEN - 1);
                    words = 0;
                    pops  = 0;
                end
            end else begin
                chk(!bus.burst_done, "spurious_done", bus.burst_done, 0);
            end
            prev_req   = bus.cmd_req;
            prev_caddr = bus.cmd_addr;
            prev_hold  = bus.wdata_valid && !bus.wdata_ready;
            prev_wd    = bus.wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noisy_step(input bit noise);
        if (noise) begin
            bus.addr_load = ($urandom_range(0, 3) == 0);
            bus.addr_init = ADDR_W'($urandom);
        end
        step();
        bus.addr_load = 1'b0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_data.push_back(w);
    endtask

    task automatic expect_bursts(input int nb);
        for (int i = 0; i < nb; i++) begin
            exp_addr.push_back(model_addr);
            model_addr = model_addr + ADDR_W'(BURST_LEN);
        end
    endtask

    task automatic load_addr(input logic [ADDR_W-1:0] a);
        bus.addr_load = 1'b1;
        bus.addr_init = a;
        model_addr    = a;
        step();
        bus.addr_load = 1'b0;
    endtask

    task automatic wait_bursts(input int tgt_req, input int tgt_done, input bit noise);
        int t;
        t = 0;
        while (n_req < tgt_req && t < 3000) begin
            noisy_step(noise);
            t++;
        end
        chk(n_req >= tgt_req, "req_timeout", n_req, tgt_req);
        bus.enable = 1'b0;
        t = 0;
        while (n_done < tgt_done && t < 3000) begin
            noisy_step(noise);
            t++;
        end
        chk(n_done >= tgt_done, "done_timeout", n_done, tgt_done);
        t = 0;
        while (bus.busy && t < 100) begin
            step();
            t++;
        end
        chk(!bus.busy, "idle_timeout", bus.busy, 0);
    endtask

    task automatic run_bursts(input int nb, input bit with_load, input logic [ADDR_W-1:0] a,
                              input bit noise);
        int r0;
        int d0;
        r0 = n_req;
        d0 = n_done;
        if (with_load) begin
            bus.addr_load = 1'b1;
            bus.addr_init = a;
            model_addr    = a;
        end
        expect_bursts(nb);
        bus.enable = 1'b1;
        step();
        bus.addr_load = 1'b0;
        wait_bursts(r0 + nb, d0 + nb, noise);
    endtask

    initial begin
        int t;
        int a0;
        int r0;
        int d0;
        int nb;
        bus.enable    = 1'b0;
        bus.addr_load = 1'b0;
        bus.addr_init = '0;

        // Reset held for two edges.
        rst = 1'b1;
        repeat (2) step();
        chk(bus.fifo_rd_en == 0, "rst_fifo_rd_en", bus.fifo_rd_en, 0);
        chk(bus.cmd_req == 0, "rst_cmd_req", bus.cmd_req, 0);
        chk(bus.cmd_addr == 0, "rst_cmd_addr", bus.cmd_addr, 0);
        chk(bus.wdata == 0, "rst_wdata", bus.wdata, 0);
        chk(bus.wdata_valid == 0, "rst_wdata_valid", bus.wdata_valid, 0);
        chk(bus.busy == 0, "rst_busy", bus.busy, 0);
        chk(bus.burst_done == 0, "rst_burst_done", bus.burst_done, 0);
        rst = 1'b0;
        step();

        // Basic burst at 0x010.
        ready_mode = 0;
        ack_delay  = 2;
        gaps       = 1'b0;
        load_addr(12'h010);
        for (int i = 0; i < BURST_LEN; i++) push_word(WIDTH'(8'hA1 + i));
        run_bursts(1, 1'b0, '0, 1'b0);
        chk(bus.cmd_addr == 12'h014, "next_cmd_addr", bus.cmd_addr, 12'h014);

        // FIFO starvation after two words.
        load_addr(12'h100);
        push_word(8'h11);
        push_word(8'h22);
        expect_bursts(1);
        r0 = n_req;
        d0 = n_done;
        bus.enable = 1'b1;
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            chk(bus.cmd_req == 0, "starve_no_req", bus.cmd_req, 0);
            chk(bus.fifo_rd_en == 0, "starve_no_rd_en", bus.fifo_rd_en, 0);
            chk(bus.busy == 1, "starve_busy", bus.busy, 1);
            step();
        end
        push_word(8'h33);
        push_word(8'h44);
        wait_bursts(r0 + 1, d0 + 1, 1'b0);

        // Backpressure with ready pattern 1,0,0.
        ready_mode = 1;
        ack_delay  = 1;
        load_addr(12'h200);
        for (int i = 0; i < 2 * BURST_LEN; i++) push_word(WIDTH'($urandom));
        run_bursts(2, 1'b0, '0, 1'b0);

        // Address wrap from 0xFFC.
        ready_mode = 0;
        load_addr(12'hFFC);
        for (int i = 0; i < 2 * BURST_LEN; i++) push_word(WIDTH'($urandom));
        run_bursts(2, 1'b0, '0, 1'b0);
        chk(bus.cmd_addr == model_addr, "addr_after_wrap", bus.cmd_addr, model_addr);

        // Randomised bursts: load with enable, stray addr_load, FIFO gaps, random ready/ack.
        ready_mode = 2;
        gaps       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ack_delay = $urandom_range(1, 4);
            nb        = $urandom_range(1, 3);
            for (int i = 0; i < nb * BURST_LEN; i++) push_word(WIDTH'($urandom));
            run_bursts(nb, 1'b1, ADDR_W'($urandom), 1'b1);
            chk(bus.cmd_addr == model_addr, "rand_addr_after", bus.cmd_addr, model_addr);
        end
        gaps = 1'b0;

        // Reset in SEND after two accepted words.
        ready_mode = 0;
        ack_delay  = 1;
        load_addr(12'h300);
        for (int i = 0; i < BURST_LEN; i++) push_word(WIDTH'(8'hC0 + i));
        expect_bursts(1);
        a0 = n_acc;
        bus.enable = 1'b1;
        step();
        t = 0;
        while (n_acc < a0 + 2 && t < 200) begin
            step();
            t++;
        end
        chk(n_acc >= a0 + 2, "acc_timeout", n_acc, a0 + 2);
        rst        = 1'b1;
        bus.enable = 1'b0;
        fifo_q.delete();
        exp_data.delete();
        exp_addr.delete();
        model_addr = '0;
        step();
        rst = 1'b0;
        chk(bus.wdata_valid == 0, "midrst_wdata_valid", bus.wdata_valid, 0);
        chk(bus.cmd_addr == 0, "midrst_cmd_addr", bus.cmd_addr, 0);
        chk(bus.burst_done == 0, "midrst_burst_done", bus.burst_done, 0);
        chk(bus.busy == 0, "midrst_busy", bus.busy, 0);
        chk(bus.cmd_req == 0, "midrst_cmd_req", bus.cmd_req, 0);

        // Fresh burst after reset starts from address 0.
        for (int i = 0; i < BURST_LEN; i++) push_word(WIDTH'($urandom));
        run_bursts(1, 1'b0, '0, 1'b0);
        chk(bus.cmd_addr == model_addr, "post_rst_addr", bus.cmd_addr, model_addr);

        chk(exp_data.size() == 0, "leftover_words", exp_data.size(), 0);
        chk(exp_addr.size() == 0, "leftover_reqs", exp_addr.size(), 0);
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
